osd_mam_wb_arb: RTL and testbench
=================================

OSD_MAM_WB_ARB -- requirements
Module: osd_mam_wb_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: Wishbone data width in bits, one of 8/16/32.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: Wishbone address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255: stalled-cycle limit, 1..65535, used only under OSD_MAM_WB_ARB_TIMEOUT_EN.
REQ-004 SHALL derive SW = DATA_WIDTH/8 as the byte-select width.
REQ-005 SHALL have one clock and an asynchronous, active-low reset, named as follows.
REQ-006 clk_i  input  1  system clock; all state changes on its rising edge.
REQ-007 rst_ni  input  1  asynchronous active-low reset.
REQ-008 mN_cyc_i, mN_stb_i, mN_we_i  input  1 each  master N (N=0: CPU, N=1: MAM Wishbone master) cycle, strobe, write enable.
REQ-009 mN_addr_i  input  ADDR_WIDTH  master N address.
REQ-010 mN_dat_i  input  DATA_WIDTH  master N write data.
REQ-011 mN_sel_i  input  SW  master N byte selects.
REQ-012 mN_cti_i / mN_bte_i  input  3 / 2  master N burst cycle type and burst type extension.
REQ-013 mN_dat_o  output  DATA_WIDTH  read data to master N.
REQ-014 mN_ack_o, mN_err_o  output  1 each  acknowledge and error to master N.
REQ-015 s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_dat_o, s_sel_o, s_cti_o, s_bte_o  output  widths as in REQ-008..012  slave-side request.
REQ-016 s_dat_i, s_ack_i, s_err_i  input  DATA_WIDTH, 1, 1  slave response.

Function
REQ-017 SHALL implement FSM states IDLE, GNT0, GNT1 (plus ABORT under REQ-028).
REQ-018 In IDLE, if exactly one mN_cyc_i is high, SHALL enter GNTN on the next edge (one-cycle arbitration latency).
REQ-019 In IDLE with both cyc high, SHALL grant the master not served last (round robin); after reset, last-served = m1, so m0 wins first.
REQ-020 In GNTN, SHALL return to IDLE on the edge where mN_cyc_i is sampled low; re-arbitration happens in IDLE, never in the same cycle.
REQ-021 A grant SHALL be held for the whole cycle, including cti=010 bursts, with no preemption.
REQ-022 In GNTN, all s_*_o request outputs SHALL equal the mN_* inputs combinationally; in IDLE/ABORT, all s_*_o SHALL be 0.
REQ-023 mN_ack_o/mN_err_o SHALL be s_ack_i/s_err_i gated by grant==N; a non-granted master SHALL see 0.
REQ-024 mN_dat_o SHALL equal s_dat_i for both masters (broadcast; qualified by ack).
REQ-025 A slave ack/err arriving in IDLE/ABORT SHALL be dropped.

Reset
REQ-026 While rst_ni is low, SHALL force IDLE, last-served=m1, timeout counter=0, and all outputs 0, independent of clk_i.
REQ-027 Reset asserted mid-burst SHALL abort the transfer immediately; after release, SHALL arbitrate afresh from IDLE.

Configuration
REQ-028 With OSD_MAM_WB_ARB_TIMEOUT_EN defined, a 16-bit counter SHALL count GNTN cycles with s_stb_o=1 and no s_ack_i/s_err_i.
  - Counter clears on ack, err, or entry to GNTN.
  - When the count reaches TIMEOUT_CYCLES, mN_err_o SHALL pulse for exactly one cycle and the FSM SHALL enter ABORT.
  - ABORT holds s_cyc_o=0 until mN_cyc_i is sampled low, then returns to IDLE.
REQ-029 Without OSD_MAM_WB_ARB_TIMEOUT_EN, SHALL have no counter and no ABORT state; mN_err_o = s_err_i gated by grant, and a stalled slave blocks indefinitely.

Verification
REQ-030 m1 single read addr 0x100, slave ack after 2 cycles with dat 0xDEADBEEF -> s_cyc_o rises 1 cycle after m1_cyc_i; m1_ack_o=1 with m1_dat_o=0xDEADBEEF; m0_ack_o stays 0.
REQ-031 m0 and m1 raise cyc in the same cycle after reset -> m0 granted first; m1 granted in the second cycle after m0_cyc_i falls; next simultaneous request goes to m0 again.
REQ-032 m1 4-beat incrementing burst (cti 010,010,010,111) while m0 requests -> m0 stays ungranted until m1_cyc_i drops; all 4 acks reach m1 only.
REQ-033 Reset pulsed during beat 2 of a burst -> s_cyc_o=0 immediately and FSM in IDLE; both masters are re-arbitrated after release.
REQ-034 Macro defined, TIMEOUT_CYCLES=8, slave never acks -> m0_err_o pulses once exactly 8 cycles after first stalled stb; s_cyc_o=0 until m0_cyc_i drops. Macro undefined -> no err; grant held.

Source files
------------

// File: rtl/osd_mam_wb_arb.sv
// Two-master Wishbone arbiter (CPU = m0, MAM = m1) with round-robin grant held for a whole cycle.
// Optional stalled-slave timeout with abort is enabled by defining OSD_MAM_WB_ARB_TIMEOUT_EN.
module osd_mam_wb_arb #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int SW            = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,

  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_dat_i,
  input  logic [SW-1:0]         m0_sel_i,
  input  logic [2:0]            m0_cti_i,
  input  logic [1:0]            m0_bte_i,
  output logic [DATA_WIDTH-1:0] m0_dat_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,

  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_dat_i,
  input  logic [SW-1:0]         m1_sel_i,
  input  logic [2:0]            m1_cti_i,
  input  logic [1:0]            m1_bte_i,
  output logic [DATA_WIDTH-1:0] m1_dat_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,

  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_addr_o,
  output logic [DATA_WIDTH-1:0] s_dat_o,
  output logic [SW-1:0]         s_sel_o,
  output logic [2:0]            s_cti_o,
  output logic [1:0]            s_bte_o,
  input  logic [DATA_WIDTH-1:0] s_dat_i,
  input  logic                  s_ack_i,
  input  logic                  s_err_i
);

  if ((DATA_WIDTH != 8) && (DATA_WIDTH != 16) && (DATA_WIDTH != 32)) begin : g_bad_width
    $error("osd_mam_wb_arb: DATA_WIDTH must be 8, 16 or 32");
  end
  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
    $error("osd_mam_wb_arb: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2
`ifdef OSD_MAM_WB_ARB_TIMEOUT_EN
    , ABORT = 2'd3
`endif
  } state_t;

  state_t state_reg;
  // Most recently granted master; also identifies the master being aborted.
  logic   last_reg;
  logic   gnt0;
  logic   gnt1;
  logic   timeout_hit;

  assign gnt0 = (state_reg == GNT0);
  assign gnt1 = (state_reg == GNT1);

`ifdef OSD_MAM_WB_ARB_TIMEOUT_EN
  logic [15:0] stall_cnt_reg;

  assign timeout_hit = (gnt0 || gnt1) && s_stb_o && !s_ack_i && !s_err_i &&
                       (stall_cnt_reg == 16'(TIMEOUT_CYCLES));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_reg <= '0;
    end else if (!(gnt0 || gnt1) || s_ack_i || s_err_i) begin
      stall_cnt_reg <= '0;
    end else if (s_stb_o && !timeout_hit) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      last_reg  <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (m0_cyc_i && m1_cyc_i) begin
            state_reg <= last_reg ? GNT0 : GNT1;
            last_reg  <= ~last_reg;
          end else if (m0_cyc_i) begin
            state_reg <= GNT0;
            last_reg  <= 1'b0;
          end else if (m1_cyc_i) begin
            state_reg <= GNT1;
            last_reg  <= 1'b1;
          end
        end
        GNT0: begin
          if (!m0_cyc_i) state_reg <= IDLE;
`ifdef OSD_MAM_WB_ARB_TIMEOUT_EN
          else if (timeout_hit) state_reg <= ABORT;
`endif
        end
        GNT1: begin
          if (!m1_cyc_i) state_reg <= IDLE;
`ifdef OSD_MAM_WB_ARB_TIMEOUT_EN
          else if (timeout_hit) state_reg <= ABORT;
`endif
        end
`ifdef OSD_MAM_WB_ARB_TIMEOUT_EN
        ABORT: begin
          if (!(last_reg ? m1_cyc_i : m0_cyc_i)) state_reg <= IDLE;
        end
`endif
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Request path is a pure mux so the granted master sees no added latency.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_addr_o = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_cti_o  = '0;
    s_bte_o  = '0;
    if (gnt0) begin
      s_cyc_o  = m0_cyc_i;
      s_stb_o  = m0_stb_i;
      s_we_o   = m0_we_i;
      s_addr_o = m0_addr_i;
      s_dat_o  = m0_dat_i;
      s_sel_o  = m0_sel_i;
      s_cti_o  = m0_cti_i;
      s_bte_o  = m0_bte_i;
    end else if (gnt1) begin
      s_cyc_o  = m1_cyc_i;
      s_stb_o  = m1_stb_i;
      s_we_o   = m1_we_i;
      s_addr_o = m1_addr_i;
      s_dat_o  = m1_dat_i;
      s_sel_o  = m1_sel_i;
      s_cti_o  = m1_cti_i;
      s_bte_o  = m1_bte_i;
    end
  end

  assign m0_ack_o = gnt0 & s_ack_i;
  assign m1_ack_o = gnt1 & s_ack_i;
  assign m0_err_o = gnt0 & (s_err_i | timeout_hit);
  assign m1_err_o = gnt1 & (s_err_i | timeout_hit);

  // Read data is broadcast; forced low while reset is held so every output is quiet.
  assign m0_dat_o = rst_ni ? s_dat_i : '0;
  assign m1_dat_o = rst_ni ? s_dat_i : '0;

endmodule

// File: tb/tb_osd_mam_wb_arb.sv
// Scoreboard bench for osd_mam_wb_arb: expected acks are queued when the slave responds
// and matched against master-side acks on the falling edge.
module tb_osd_mam_wb_arb;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic          m_cyc [2];
  logic          m_stb [2];
  logic          m_we  [2];
  logic [AW-1:0] m_addr[2];
  logic [DW-1:0] m_dat [2];
  logic [SW-1:0] m_sel [2];
  logic [2:0]    m_cti [2];
  logic [1:0]    m_bte [2];

  logic [DW-1:0] m0_dat_o, m1_dat_o;
  logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_addr_o;
  logic [DW-1:0] s_dat_o;
  logic [SW-1:0] s_sel_o;
  logic [2:0]    s_cti_o;
  logic [1:0]    s_bte_o;
  logic [DW-1:0] s_dat_i = '0;
  logic          s_ack_i = 1'b0;
  logic          s_err_i = 1'b0;

  osd_mam_wb_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]), .m0_addr_i(m_addr[0]),
    .m0_dat_i(m_dat[0]), .m0_sel_i(m_sel[0]), .m0_cti_i(m_cti[0]), .m0_bte_i(m_bte[0]),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]), .m1_addr_i(m_addr[1]),
    .m1_dat_i(m_dat[1]), .m1_sel_i(m_sel[1]), .m1_cti_i(m_cti[1]), .m1_bte_i(m_bte[1]),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
    .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          m;
    logic [DW-1:0] dat;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int n, input logic cyc, input logic [AW-1:0] addr, input logic [2:0] cti);
    m_cyc[n]  = cyc;
    m_stb[n]  = cyc;
    m_we[n]   = 1'b0;
    m_addr[n] = addr;
    m_dat[n]  = cyc ? (addr ^ 32'h5A5A_5A5A) : '0;
    m_sel[n]  = cyc ? '1 : '0;
    m_cti[n]  = cti;
    m_bte[n]  = 2'b00;
  endtask

  task automatic ack_on(input logic m, input logic [DW-1:0] d);
    exp_t e;
    e.m   = m;
    e.dat = d;
    sb_q.push_back(e);
    s_ack_i = 1'b1;
    s_dat_i = d;
  endtask

  task automatic check_grant(input string tag, input logic [AW-1:0] addr);
    check({tag, "_cyc"}, s_cyc_o, 1'b1);
    check({tag, "_addr"}, s_addr_o, addr);
    check({tag, "_wdat"}, s_dat_o, addr ^ 32'h5A5A_5A5A);
    check({tag, "_sel"}, s_sel_o, 4'hF);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cyc"}, s_cyc_o, 1'b0);
    check({tag, "_stb"}, s_stb_o, 1'b0);
    check({tag, "_addr"}, s_addr_o, 32'h0);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    s_ack_i = 1'b0;
    s_dat_i = 32'hFFFF_FFFF;
    drive(0, 1'b0, '0, 3'b000);
    drive(1, 1'b0, '0, 3'b000);
    #1;
    check_idle("rst");
    check("rst_m0_dat", m0_dat_o, 32'h0);
    check("rst_m1_ack", m1_ack_o, 1'b0);
    step();
    step();
    rst_n   = 1'b1;
    s_dat_i = '0;
  endtask

  // Every master-side ack must match the oldest queued slave response.
  always @(negedge clk) begin
    if (rst_n && (m0_ack_o || m1_ack_o)) begin
      check("dual_ack", m0_ack_o & m1_ack_o, 1'b0);
      if (sb_q.size() == 0) begin
        check("sb_depth", sb_q.size(), 1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("ack_master", m1_ack_o, e.m);
        check("ack_data", e.m ? m1_dat_o : m0_dat_o, e.dat);
        $display("txn ack m%0d data %08h", e.m, e.dat);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Single read by m1, slave acks in the second granted cycle.
    do_reset();
    drive(1, 1'b1, 32'h100, 3'b000);
    @(negedge clk);
    check("s1_latency", s_cyc_o, 1'b0);
    step();
    @(negedge clk);
    check_grant("s1_gnt", 32'h100);
    check("s1_wait_ack", m1_ack_o, 1'b0);
    step();
    ack_on(1'b1, 32'hDEAD_BEEF);
    @(negedge clk);
    check("s1_m0_ack", m0_ack_o, 1'b0);
    step();
    s_ack_i = 1'b0;
    drive(1, 1'b0, '0, 3'b000);
    @(negedge clk);
    check("s1_cyc_drop", s_cyc_o, 1'b0);
    step();
    @(negedge clk);
    check_idle("s1_idle");
    check("s1_sb", sb_q.size(), 0);

    // Simultaneous requests after reset: m0 first, then m1, then m0 again.
    do_reset();
    drive(0, 1'b1, 32'h200, 3'b000);
    drive(1, 1'b1, 32'h300, 3'b000);
    @(negedge clk);
    check("s2_latency", s_cyc_o, 1'b0);
    step();
    ack_on(1'b0, 32'h1111_2222);
    @(negedge clk);
    check_grant("s2_first", 32'h200);
    step();
    s_ack_i = 1'b0;
    drive(0, 1'b0, '0, 3'b000);
    step();
    @(negedge clk);
    check_idle("s2_gap");
    step();
    ack_on(1'b1, 32'h3333_4444);
    @(negedge clk);
    check_grant("s2_second", 32'h300);
    step();
    s_ack_i = 1'b0;
    drive(1, 1'b0, '0, 3'b000);
    step();
    drive(0, 1'b1, 32'h204, 3'b000);
    drive(1, 1'b1, 32'h304, 3'b000);
    step();
    ack_on(1'b0, 32'h5555_6666);
    @(negedge clk);
    check_grant("s2_rr", 32'h204);
    step();
    s_ack_i = 1'b0;
    drive(0, 1'b0, '0, 3'b000);
    drive(1, 1'b0, '0, 3'b000);
    step();
    step();
    check("s2_sb", sb_q.size(), 0);

    // m1 incrementing burst with m0 waiting; m0 was served last so m1 wins.
    drive(1, 1'b1, 32'h400, 3'b010);
    drive(0, 1'b1, 32'h500, 3'b000);
    step();
    for (int b = 0; b < 4; b++) begin
      step();
      ack_on(1'b1, 32'hB0B0_0000 + 32'(b));
      @(negedge clk);
      check_grant($sformatf("s3_beat%0d", b), 32'h400 + 32'(4 * b));
      check($sformatf("s3_cti%0d", b), s_cti_o, (b == 3) ? 3'b111 : 3'b010);
      check($sformatf("s3_m0_blk%0d", b), m0_ack_o, 1'b0);
      if (b < 3) begin
        @(posedge clk);
        #1;
        s_ack_i = 1'b0;
        drive(1, 1'b1, 32'h400 + 32'(4 * (b + 1)), (b == 2) ? 3'b111 : 3'b010);
        ack_on(1'b1, 32'hB0B0_0000 + 32'(b + 1));
        sb_q.pop_back();
        s_ack_i = 1'b0;
        @(negedge clk);
        check($sformatf("s3_hold%0d", b), s_addr_o, 32'h400 + 32'(4 * (b + 1)));
      end
    end
    step();
    s_ack_i = 1'b0;
    drive(1, 1'b0, '0, 3'b000);
    @(negedge clk);
    check("s3_m1_drop", s_cyc_o, 1'b0);
    step();
    step();
    ack_on(1'b0, 32'hC0C0_0001);
    @(negedge clk);
    check_grant("s3_m0_after", 32'h500);
    step();
    s_ack_i = 1'b0;
    drive(0, 1'b0, '0, 3'b000);
    step();
    step();
    check("s3_sb", sb_q.size(), 0);

    // Reset asserted during beat 2 of an m0 burst.
    drive(0, 1'b1, 32'h600, 3'b010);
    step();
    ack_on(1'b0, 32'hA000_0001);
    @(negedge clk);
    check_grant("s4_beat1", 32'h600);
    step();
    s_ack_i = 1'b0;
    drive(0, 1'b1, 32'h604, 3'b010);
    @(negedge clk);
    check_grant("s4_beat2", 32'h604);
    #1;
    rst_n   = 1'b0;
    s_ack_i = 1'b1;
    #1;
    check("s4_rst_cyc", s_cyc_o, 1'b0);
    check("s4_rst_ack", m0_ack_o, 1'b0);
    check("s4_rst_addr", s_addr_o, 32'h0);
    step();
    drive(1, 1'b1, 32'h700, 3'b000);
    step();
    check("s4_rst_hold", s_cyc_o, 1'b0);
    s_ack_i = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    check("s4_rel_idle", s_cyc_o, 1'b0);
    step();
    ack_on(1'b0, 32'hA000_0002);
    @(negedge clk);
    check_grant("s4_rearb", 32'h604);
    step();
    s_ack_i = 1'b0;
    drive(0, 1'b0, '0, 3'b000);
    step();
    step();
    ack_on(1'b1, 32'hA000_0003);
    @(negedge clk);
    check_grant("s4_m1", 32'h700);
    step();
    s_ack_i = 1'b0;
    drive(1, 1'b0, '0, 3'b000);
    step();
    step();
    check("s4_sb", sb_q.size(), 0);

    // Slave never responds to m0.
    drive(0, 1'b1, 32'h800, 3'b000);
    step();
`ifdef OSD_MAM_WB_ARB_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("s5_no_err%0d", i), m0_err_o, 1'b0);
      check($sformatf("s5_cyc%0d", i), s_cyc_o, 1'b1);
      step();
    end
    @(negedge clk);
    check("s5_err_pulse", m0_err_o, 1'b1);
    check("s5_m1_err", m1_err_o, 1'b0);
    step();
    @(negedge clk);
    check("s5_err_once", m0_err_o, 1'b0);
    check("s5_abort_cyc", s_cyc_o, 1'b0);
    step();
    @(negedge clk);
    check("s5_abort_hold", s_cyc_o, 1'b0);
    step();
    drive(0, 1'b0, '0, 3'b000);
    step();
    @(negedge clk);
    check_idle("s5_idle");
`else
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("s5_no_err%0d", i), m0_err_o, 1'b0);
      check($sformatf("s5_cyc%0d", i), s_cyc_o, 1'b1);
      step();
    end
    drive(0, 1'b0, '0, 3'b000);
    step();
    @(negedge clk);
    check_idle("s5_idle");
`endif

    check("final_sb", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
